// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM micro-op sequencer for the ID-RF stage
module lm_sm_sequencer #(
    parameter int DATA_W = 16,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [MASK_W-1:0] reg_mask,
    input  logic              hold_in,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              uop_valid,
    output logic              uop_store,
    output logic [2:0]        uop_reg,
    output logic [DATA_W-1:0] uop_addr,
    output logic              uop_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [MASK_W-1:0] rem_mask, rem_mask_nx, rem_clr;
    logic [DATA_W-1:0] cur_addr, cur_addr_nx;
    logic              st_r, st_r_nx;
    logic [2:0]        low_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem_mask <= '0;
            cur_addr <= '0;
            st_r     <= 1'b0;
        end else begin
            state    <= state_nx;
            rem_mask <= rem_mask_nx;
            cur_addr <= cur_addr_nx;
            st_r     <= st_r_nx;
        end
    end

    // Descending scan so the lowest set bit wins (R0 issued first)
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (rem_mask[i]) low_idx = 3'(i);
        end
        rem_clr = rem_mask & (rem_mask - MASK_W'(1));
    end

    always_comb begin
        state_nx    = state;
        rem_mask_nx = rem_mask;
        cur_addr_nx = cur_addr;
        st_r_nx     = st_r;
        stall       = 1'b0;
        uop_valid   = 1'b0;
        uop_last    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    rem_mask_nx = '0;
                end else if (start && (reg_mask != '0)) begin
                    // Instruction stays in IF/ID until the sequencer takes it
                    stall = 1'b1;
                    if (!hold_in) begin
                        state_nx    = RUN;
                        rem_mask_nx = reg_mask;
                        cur_addr_nx = base_addr;
                        st_r_nx     = is_store;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_nx    = IDLE;
                    rem_mask_nx = '0;
                end else if (hold_in) begin
                    stall = 1'b1;
                end else begin
                    uop_valid   = 1'b1;
                    uop_last    = (rem_clr == '0);
                    stall       = ~uop_last;
                    rem_mask_nx = rem_clr;
                    cur_addr_nx = cur_addr + DATA_W'(1);
                    if (uop_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign uop_store = uop_valid & st_r;
    assign uop_reg   = uop_valid ? low_idx : 3'd0;
    assign uop_addr  = uop_valid ? cur_addr : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - directed self-checking bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, is_store, hold_in, flush;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        busy, stall, uop_valid, uop_store, uop_last;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;

    int vectors = 0;
    int miscompares = 0;

    lm_sm_sequencer #(.DATA_W(16), .MASK_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_mask(reg_mask), .hold_in(hold_in),
        .flush(flush), .busy(busy), .stall(stall), .uop_valid(uop_valid),
        .uop_store(uop_store), .uop_reg(uop_reg), .uop_addr(uop_addr),
        .uop_last(uop_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic st, input logic [15:0] b,
                          input logic [7:0] m, input logic h, input logic f);
        start = s; is_store = st; base_addr = b; reg_mask = m; hold_in = h; flush = f;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic st,
                              input logic [2:0] r, input logic [15:0] a,
                              input logic l, input logic s, input logic b);
        chk({tag, ".uop_valid"}, 32'(uop_valid), 32'(v));
        chk({tag, ".uop_store"}, 32'(uop_store), 32'(st));
        chk({tag, ".uop_reg"},   32'(uop_reg),   32'(r));
        chk({tag, ".uop_addr"},  32'(uop_addr),  32'(a));
        chk({tag, ".uop_last"},  32'(uop_last),  32'(l));
        chk({tag, ".stall"},     32'(stall),     32'(s));
        chk({tag, ".busy"},      32'(busy),      32'(b));
    endtask

    // Called at a falling edge with inputs already applied; checks then advances one cycle
    task automatic cyc(input string tag, input logic v, input logic st,
                       input logic [2:0] r, input logic [15:0] a,
                       input logic l, input logic s, input logic b);
        #1;
        check_outs(tag, v, st, r, a, l, s, b);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        #1;
        check_outs("reset", 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        // LM base 0x0010 mask 0xA5; start held high with junk operands while in RUN
        set_in(1, 0, 16'h0010, 8'hA5, 0, 0);
        cyc("lm.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(1, 1, 16'hAAAA, 8'hFF, 0, 0);
        cyc("lm.r0", 1, 0, 3'd0, 16'h0010, 0, 1, 1);
        cyc("lm.r2", 1, 0, 3'd2, 16'h0011, 0, 1, 1);
        cyc("lm.r5", 1, 0, 3'd5, 16'h0012, 0, 1, 1);
        cyc("lm.r7", 1, 0, 3'd7, 16'h0013, 1, 0, 1);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("lm.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // SM base 0xFFFF mask 0x80: single micro-op
        set_in(1, 1, 16'hFFFF, 8'h80, 0, 0);
        cyc("sm.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("sm.r7", 1, 1, 3'd7, 16'hFFFF, 1, 0, 1);
        cyc("sm.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // Empty mask behaves as a NOP
        set_in(1, 0, 16'h1234, 8'h00, 0, 0);
        cyc("nop.s0", 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("nop.s1", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // Flush in IDLE beats start
        set_in(1, 0, 16'h0020, 8'h01, 0, 1);
        cyc("iflush.s0", 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("iflush.s1", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // Full mask with address wrap and a two-cycle hold after R2
        set_in(1, 0, 16'hFFFE, 8'hFF, 0, 0);
        cyc("wrap.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("wrap.r0", 1, 0, 3'd0, 16'hFFFE, 0, 1, 1);
        cyc("wrap.r1", 1, 0, 3'd1, 16'hFFFF, 0, 1, 1);
        cyc("wrap.r2", 1, 0, 3'd2, 16'h0000, 0, 1, 1);
        set_in(0, 0, 16'h0000, 8'h00, 1, 0);
        cyc("wrap.h1", 0, 0, 3'd0, 16'h0000, 0, 1, 1);
        cyc("wrap.h2", 0, 0, 3'd0, 16'h0000, 0, 1, 1);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("wrap.r3", 1, 0, 3'd3, 16'h0001, 0, 1, 1);
        cyc("wrap.r4", 1, 0, 3'd4, 16'h0002, 0, 1, 1);
        cyc("wrap.r5", 1, 0, 3'd5, 16'h0003, 0, 1, 1);
        cyc("wrap.r6", 1, 0, 3'd6, 16'h0004, 0, 1, 1);
        cyc("wrap.r7", 1, 0, 3'd7, 16'h0005, 1, 0, 1);
        cyc("wrap.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // Flush after R0,R1 of mask 0x0F, then a fresh single-register LM
        set_in(1, 1, 16'h0100, 8'h0F, 0, 0);
        cyc("fl.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("fl.r0", 1, 1, 3'd0, 16'h0100, 0, 1, 1);
        cyc("fl.r1", 1, 1, 3'd1, 16'h0101, 0, 1, 1);
        set_in(0, 0, 16'h0000, 8'h00, 1, 1);
        cyc("fl.flush", 0, 0, 3'd0, 16'h0000, 0, 0, 1);
        set_in(1, 0, 16'h0040, 8'h01, 0, 0);
        cyc("fl.new.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("fl.new.r0", 1, 0, 3'd0, 16'h0040, 1, 0, 1);
        cyc("fl.new.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        // Asynchronous reset in the middle of a RUN
        set_in(1, 1, 16'h0200, 8'h0C, 0, 0);
        cyc("ar.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        #1;
        check_outs("ar.r2", 1, 1, 3'd2, 16'h0200, 0, 1, 1);
        #1 reset = 1'b1;
        #1;
        check_outs("ar.async", 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        cyc("ar.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        set_in(1, 0, 16'h0300, 8'h02, 0, 0);
        cyc("ar.new.s0", 0, 0, 3'd0, 16'h0000, 0, 1, 0);
        set_in(0, 0, 16'h0000, 8'h00, 0, 0);
        cyc("ar.new.r1", 1, 0, 3'd1, 16'h0300, 1, 0, 1);
        cyc("ar.new.idle", 0, 0, 3'd0, 16'h0000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
